// File: rtl/fiber_fib2glb_blk.sv
// Drains a block-mode fiber stream (header, payload words, DONE token) into sequential GLB word writes.
// Latency 1 from token handshake to glb_wen; a stalled GLB write (glb_ready=0) drops data_in_ready.
module fiber_fib2glb_blk #(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 16,
    parameter logic [DATA_W:0] DONE_TOKEN = 17'h10100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W:0]   data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [DATA_W-1:0] glb_data,
    output logic              glb_wen,
    input  logic              glb_ready,
    output logic              done,
    output logic              err,
    output logic [15:0]       blk_count,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   remaining;
    logic                acc, is_ctl, is_done;
    logic                wr, ctl_err;
    logic                wen_nxt;

    assign data_in_ready = clk_en && (state == HDR || state == DATA) && (!glb_wen || glb_ready);
    assign acc     = data_in_valid && data_in_ready;
    assign is_ctl  = data_in[DATA_W];
    assign is_done = (data_in == DONE_TOKEN);
    // The output register stays occupied if it is reloaded or its write is still stalled.
    assign wen_nxt = wr || (glb_wen && !glb_ready);

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        ctl_err   = 1'b0;
        case (state)
            IDLE: begin
                if (tile_en) state_nxt = HDR;
            end
            HDR: begin
                if (acc) begin
                    if (is_done) begin
                        state_nxt = DONE;
                    end else if (is_ctl) begin
                        ctl_err = 1'b1;
                    end else begin
                        wr = 1'b1;
                        if (data_in[DATA_W-1:0] != '0) state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    if (is_ctl) begin
                        ctl_err = 1'b1;
                    end else begin
                        wr = 1'b1;
                        if (remaining == DATA_W'(1)) state_nxt = HDR;
                    end
                end
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            glb_wen    <= 1'b0;
            glb_addr   <= '0;
            glb_data   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            blk_count  <= '0;
            word_count <= '0;
        end else if (flush) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            glb_wen    <= 1'b0;
            glb_addr   <= '0;
            glb_data   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            blk_count  <= '0;
            word_count <= '0;
        end else if (clk_en) begin
            state <= state_nxt;
            if (state == IDLE && tile_en) ptr <= start_addr;
            if (wr) begin
                glb_wen  <= 1'b1;
                glb_addr <= ptr;
                glb_data <= data_in[DATA_W-1:0];
                ptr      <= ptr + ADDR_W'(1);
                // Running past the top of the address space is a protocol error.
                if (&ptr) err <= 1'b1;
            end else if (glb_ready) begin
                glb_wen <= 1'b0;
            end
            if (ctl_err) err <= 1'b1;
            if (glb_wen && glb_ready) word_count <= word_count + ADDR_W'(1);
            if (wr && state == HDR) begin
                blk_count <= blk_count + 16'd1;
                remaining <= data_in[DATA_W-1:0];
            end else if (wr) begin
                remaining <= remaining - DATA_W'(1);
            end
            done <= (state_nxt == DONE) && !wen_nxt;
        end
    end

endmodule

// File: tb/tb_fiber_fib2glb_blk.sv
// Directed bench for fiber_fib2glb_blk: cycle table for a single block, then stream-level scoreboarded sequences.
module tb_fiber_fib2glb_blk;

    localparam logic [16:0] DONE_TOK = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, tile_en;
    logic [15:0] start_addr;
    logic [16:0] data_in;
    logic        data_in_valid, data_in_ready;
    logic [15:0] glb_addr, glb_data;
    logic        glb_wen, glb_ready;
    logic        done, err;
    logic [15:0] blk_count, word_count;

    fiber_fib2glb_blk dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .start_addr(start_addr), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .glb_addr(glb_addr), .glb_data(glb_data),
        .glb_wen(glb_wen), .glb_ready(glb_ready), .done(done), .err(err),
        .blk_count(blk_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [16:0] tok_q[$];
    logic [15:0] wa_q[$], wd_q[$], ea_q[$], ed_q[$];

    typedef struct {
        logic        vld;
        logic [16:0] dat;
        logic        gr;
        logic        rdy;
        logic        wen;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic        dn;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Records every retired GLB write, sampled after the inputs of the cycle have settled.
    always @(negedge clk) begin
        #1;
        if (rst_n && !flush && clk_en && glb_wen && glb_ready) begin
            wa_q.push_back(glb_addr);
            wd_q.push_back(glb_data);
        end
    end

    task automatic do_flush(input logic [15:0] sa);
        @(negedge clk);
        flush = 1'b1; data_in_valid = 1'b0; glb_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; tile_en = 1'b1; start_addr = sa;
        wa_q.delete(); wd_q.delete(); ea_q.delete(); ed_q.delete();
    endtask

    task automatic run_stream(input bit gaps);
        int idx = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done) break;
            data_in_valid = (idx < tok_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
            data_in       = (idx < tok_q.size()) ? tok_q[idx] : 17'h0;
            glb_ready     = !gaps || ($urandom_range(0, 3) != 0);
            #1;
            if (data_in_valid && data_in_ready) idx++;
        end
        data_in_valid = 1'b0;
        glb_ready     = 1'b1;
        chk("stream_done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_writes(input string name);
        chk({name, "_nwr"}, wa_q.size(), ea_q.size());
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), {16'd0, wa_q[i]}, {16'd0, ea_q[i]});
            chk($sformatf("%s_data%0d", name, i), {16'd0, wd_q[i]}, {16'd0, ed_q[i]});
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        ea_q.push_back(a);
        ed_q.push_back(d);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b0; start_addr = 16'h0;
        data_in = 17'h0; data_in_valid = 1'b0; glb_ready = 1'b1;

        tbl[0] = '{1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 17'h00003, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 17'h0000A, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0003, 1'b0};
        tbl[3] = '{1'b1, 17'h0000B, 1'b1, 1'b1, 1'b1, 16'h0011, 16'h000A, 1'b0};
        tbl[4] = '{1'b1, 17'h0000C, 1'b1, 1'b1, 1'b1, 16'h0012, 16'h000B, 1'b0};
        tbl[5] = '{1'b1, DONE_TOK,  1'b1, 1'b1, 1'b1, 16'h0013, 16'h000C, 1'b0};
        tbl[6] = '{1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 16'h0013, 16'h000C, 1'b1};

        @(negedge clk);
        #1;
        chk("rst_wen",  {31'd0, glb_wen}, 32'd0);
        chk("rst_addr", {16'd0, glb_addr}, 32'd0);
        chk("rst_rdy",  {31'd0, data_in_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wc",   {16'd0, word_count}, 32'd0);
        rst_n = 1'b1;

        // Single block at full throughput, checked cycle by cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin tile_en = 1'b1; start_addr = 16'h0010; end
            data_in_valid = tbl[i].vld; data_in = tbl[i].dat; glb_ready = tbl[i].gr;
            #1;
            chk($sformatf("t1_rdy%0d", i),  {31'd0, data_in_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("t1_wen%0d", i),  {31'd0, glb_wen}, {31'd0, tbl[i].wen});
            chk($sformatf("t1_addr%0d", i), {16'd0, glb_addr}, {16'd0, tbl[i].addr});
            chk($sformatf("t1_data%0d", i), {16'd0, glb_data}, {16'd0, tbl[i].wdat});
            chk($sformatf("t1_done%0d", i), {31'd0, done}, {31'd0, tbl[i].dn});
        end
        data_in_valid = 1'b0;
        chk("t1_blk", {16'd0, blk_count}, 32'd1);
        chk("t1_wc",  {16'd0, word_count}, 32'd4);
        chk("t1_err", {31'd0, err}, 32'd0);

        // Two blocks plus an empty block, random valid and ready gaps.
        do_flush(16'h0020);
        tok_q = '{17'h00002, 17'h01234, 17'h0BEEF, 17'h00000, 17'h00001, 17'h000AA, DONE_TOK};
        exp_wr(16'h0020, 16'h0002); exp_wr(16'h0021, 16'h1234); exp_wr(16'h0022, 16'hBEEF);
        exp_wr(16'h0023, 16'h0000); exp_wr(16'h0024, 16'h0001); exp_wr(16'h0025, 16'h00AA);
        run_stream(1'b1);
        check_writes("t2");
        chk("t2_blk", {16'd0, blk_count}, 32'd3);
        chk("t2_wc",  {16'd0, word_count}, 32'd6);
        chk("t2_err", {31'd0, err}, 32'd0);

        // Control token inside a block's payload is dropped and flagged.
        do_flush(16'h0040);
        tok_q = '{17'h00003, 17'h00050, 17'h10005, 17'h00051, 17'h00052, DONE_TOK};
        exp_wr(16'h0040, 16'h0003); exp_wr(16'h0041, 16'h0050);
        exp_wr(16'h0042, 16'h0051); exp_wr(16'h0043, 16'h0052);
        run_stream(1'b0);
        check_writes("t3");
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_wc",  {16'd0, word_count}, 32'd4);

        // Address wrap past 0xFFFF.
        do_flush(16'hFFFE);
        tok_q = '{17'h00002, 17'h0000A, 17'h0000B, DONE_TOK};
        exp_wr(16'hFFFE, 16'h0002); exp_wr(16'hFFFF, 16'h000A); exp_wr(16'h0000, 16'h000B);
        run_stream(1'b0);
        check_writes("t4");
        chk("t4_err", {31'd0, err}, 32'd1);

        // Flush while a stalled write is pending mid-payload, then a fresh stream.
        do_flush(16'h0050);
        @(negedge clk); data_in_valid = 1'b0;
        @(negedge clk); data_in_valid = 1'b1; data_in = 17'h00003; glb_ready = 1'b1;
        @(negedge clk); data_in = 17'h00077; glb_ready = 1'b0;
        #1;
        chk("t5_pend_wen", {31'd0, glb_wen}, 32'd1);
        chk("t5_stall_rdy", {31'd0, data_in_ready}, 32'd0);
        @(negedge clk); flush = 1'b1; data_in_valid = 1'b0;
        @(negedge clk); flush = 1'b0; start_addr = 16'h0060; glb_ready = 1'b1;
        #1;
        chk("t5_wen",  {31'd0, glb_wen}, 32'd0);
        chk("t5_addr", {16'd0, glb_addr}, 32'd0);
        chk("t5_data", {16'd0, glb_data}, 32'd0);
        chk("t5_blk",  {16'd0, blk_count}, 32'd0);
        chk("t5_rdy",  {31'd0, data_in_ready}, 32'd0);
        wa_q.delete(); wd_q.delete();
        tok_q = '{17'h00001, 17'h00051, DONE_TOK};
        exp_wr(16'h0060, 16'h0001); exp_wr(16'h0061, 16'h0051);
        run_stream(1'b0);
        check_writes("t5");
        chk("t5_wc", {16'd0, word_count}, 32'd2);

        // clk_en low for 5 cycles mid-block freezes everything.
        do_flush(16'h0070);
        @(negedge clk); data_in_valid = 1'b0;
        @(negedge clk); data_in_valid = 1'b1; data_in = 17'h00003;
        @(negedge clk); data_in = 17'h0000A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clk_en = 1'b0; data_in = 17'h0000B;
            #1;
            chk($sformatf("t6_rdy%0d", i),  {31'd0, data_in_ready}, 32'd0);
            chk($sformatf("t6_wen%0d", i),  {31'd0, glb_wen}, 32'd1);
            chk($sformatf("t6_addr%0d", i), {16'd0, glb_addr}, 32'h71);
        end
        @(negedge clk); clk_en = 1'b1; data_in_valid = 1'b0;
        chk("t6_wc_frozen", {16'd0, word_count}, 32'd1);
        tok_q = '{17'h0000B, 17'h0000C, DONE_TOK};
        exp_wr(16'h0070, 16'h0003); exp_wr(16'h0071, 16'h000A);
        exp_wr(16'h0072, 16'h000B); exp_wr(16'h0073, 16'h000C);
        run_stream(1'b0);
        check_writes("t6");
        chk("t6_blk", {16'd0, blk_count}, 32'd1);

        // Asynchronous reset pulse between clock edges.
        do_flush(16'h0080);
        @(negedge clk); data_in_valid = 1'b0;
        @(negedge clk); data_in_valid = 1'b1; data_in = 17'h00002; glb_ready = 1'b0;
        @(negedge clk); data_in_valid = 1'b0;
        #1;
        chk("t7_pre_wen", {31'd0, glb_wen}, 32'd1);
        #6 rst_n = 1'b0;
        #1;
        chk("t7_wen",  {31'd0, glb_wen}, 32'd0);
        chk("t7_addr", {16'd0, glb_addr}, 32'd0);
        chk("t7_blk",  {16'd0, blk_count}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fiber_fib2glb_blk.md
# fiber_fib2glb_blk

Block-mode drain for a fiber access tile: accepts the 17-bit block stream a fiber access read scanner emits in block mode (length header, then payload words, then DONE token) and writes every header and payload word sequentially into a GLB-side single-port write interface. It is the fiber-to-GLB counterpart of the GLB block writer that feeds the write scanner. It lets sparse unit tests and top-level integration capture tile contents back into global buffer memory.

## Interface
- DATA_W, 16, payload width; stream tokens are DATA_W+1 bits, MSB = control flag
- ADDR_W, 16, GLB word address width
- DONE_TOKEN, 17'h10100, end-of-stream control token

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global clock enable; when 0, all state and outputs hold and data_in_ready=0
- flush  in  1  synchronous flush; same effect as reset, clk_en not required
- tile_en  in  1  block enable; 0 holds the FSM in IDLE
- start_addr  in  ADDR_W  first GLB address, sampled on IDLE->HDR
- data_in  in  DATA_W+1  block-stream token
- data_in_valid  in  1  token valid
- data_in_ready  out  1  token accepted when valid&ready
- glb_addr  out  ADDR_W  write address
- glb_data  out  DATA_W  write data
- glb_wen  out  1  write request; held with addr/data until glb_ready
- glb_ready  in  1  GLB accepts write when glb_wen&glb_ready
- done  out  1  stream finished and all writes retired
- err  out  1  sticky protocol error
- blk_count  out  16  headers accepted
- word_count  out  ADDR_W  words written (headers + payload)

## Operation
- States: IDLE, HDR, DATA, DONE.
- IDLE: data_in_ready=0. If tile_en, load addr pointer from start_addr, go HDR next cycle.
- HDR: accepted token:
  - == DONE_TOKEN -> DONE (no write).
  - other control token (MSB=1) -> err=1, token dropped, stay HDR.
  - data word N -> write N, blk_count+1; N==0 stays HDR, else remaining=N, go DATA.
- DATA: accepted data word -> write, remaining-1; remaining reaching 0 -> HDR. Control token (incl. DONE) in DATA -> err=1, dropped, remaining unchanged.
- DONE: data_in_ready=0; done=1 once output register empty; holds until flush/reset. tile_en low in DONE does not clear.
- Writes go through a one-entry output register (glb_addr/glb_data/glb_wen). Each write uses current pointer, then pointer+1 mod 2^ADDR_W; word_count+1 when write retires.
- Pointer wrap past 2^ADDR_W-1 back to start_addr's address space: address wraps to 0 and err=1 (sticky).
- tile_en dropping in HDR/DATA: no effect mid-stream; only IDLE checks it.

## Timing
- Reset/flush values: state IDLE, data_in_ready=0, glb_wen=0, glb_addr=0, glb_data=0, done=0, err=0, blk_count=0, word_count=0, remaining=0.
- data_in_ready = clk_en & (state in HDR,DATA) & (!glb_wen | glb_ready); combinational from state and glb_ready, no dependence on data_in_valid.
- Handshake at cycle t -> glb_wen=1 with addr/data at t+1 (latency 1). Back-to-back tokens at full throughput when glb_ready=1.
- glb_ready=0: glb_wen/addr/data stable, data_in_ready=0, no tokens lost.
- Simultaneous retire and new accept in same cycle: register reloads, glb_wen stays 1.
- done rises the cycle after the last write retires, or the cycle after DONE_TOKEN accepted if register already empty.
- clk_en=0 freezes everything including pending glb_wen.

## Test plan
- start_addr=0x10, stream 3,A,B,C,DONE, glb_ready=1 -> writes 0x10:3,0x11:A,0x12:B,0x13:C; blk_count=1, word_count=4, done one cycle after last write, err=0.
- Two blocks 2,X,Y,0,1,Z,DONE with random valid and glb_ready gaps -> 6 writes at consecutive addresses in order, blk_count=3, no duplicates/drops.
- Control token 0x10005 in DATA of block 3,P,<ctl>,Q,R,DONE -> err=1, writes 3,P,Q,R only, done=1.
- start_addr=0xFFFE, stream 2,A,B,DONE -> writes at 0xFFFE,0xFFFF,0x0000; err=1 on wrap.
- Flush asserted mid-DATA with glb_wen pending -> next cycle all outputs at reset values, state IDLE; new stream then completes normally.
- rst_n pulsed low asynchronously between edges -> outputs clear immediately; clk_en=0 for 5 cycles mid-block -> no handshakes, outputs frozen, resumes exactly.
